square_q8_16: RTL and testbench



---
 rtl/square_q8_16.sv | 144 ++++++++++++++
 tb/tb_square_q8_16.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/square_q8_16.sv
// -----------------------------------------------------------------------------
// square_q8_16
//
// Sequential shift-add squarer. Squares a 24-bit unsigned Q8.16 operand and
// returns a 32-bit unsigned Q16.16 result, rounded half up at bit 15.
// Handshake:
//   - A rising edge on Start, sampled in IDLE, is the accepting edge (E0).
//   - InpNum is captured on that edge and on no other.
//   - Start edges seen while Busy are dropped; they are not queued.
//   - Stop pulses high for exactly one cycle, 24 edges after E0.
//   - Result is valid from the Stop edge onward and holds until the next
//     completion.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   Rst_n     in   1   asynchronous active-low reset
//   Start     in   1   request (rising edge only, via internal one-shot)
//   InpNum    in   24  operand, unsigned Q8.16
//   Result    out  32  square, unsigned Q16.16, registered
//   Busy      out  1   high from accepting edge until return to IDLE
//   Stop      out  1   single-cycle completion pulse
//   dbg_state out  2   current FSM state (IDLE=0, CALC=1, DONE=2)
// -----------------------------------------------------------------------------
module square_q8_16 (
    input  logic        clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [23:0] InpNum,
    output logic [31:0] Result,
    output logic        Busy,
    output logic        Stop,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0]  LAST_CNT = 5'd23;
    localparam logic [47:0] ROUND_HALF = 48'h0000_0000_8000;

    logic [1:0]  state_q,      state_d;
    logic        start_prev_q, start_prev_d;
    logic [23:0] mplier_q,     mplier_d;
    logic [47:0] mcand_q,      mcand_d;
    logic [47:0] acc_q,        acc_d;
    logic [4:0]  cnt_q,        cnt_d;
    logic [31:0] result_q,     result_d;
    logic        busy_q,       busy_d;
    logic        stop_q,       stop_d;

    logic        start_rise;
    logic [47:0] acc_sum;
    logic [47:0] acc_rounded;

    // One-shot: a held Start only counts once. start_prev_q is cleared by
    // reset, so Start already high at release is treated as a rising edge.
    assign start_rise = Start & ~start_prev_q;

    // Partial product for the current multiplier bit, and the rounded full
    // product used on the last CALC edge. No overflow is possible:
    // (2^24-1)^2 + 2^15 < 2^48.
    assign acc_sum     = acc_q + (mplier_q[0] ? mcand_q : 48'd0);
    assign acc_rounded = acc_sum + ROUND_HALF;

    always_comb begin
        state_d      = state_q;
        start_prev_d = Start;
        mplier_d     = mplier_q;
        mcand_d      = mcand_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        busy_d       = busy_q;
        stop_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    mplier_d = InpNum;
                    mcand_d  = {24'd0, InpNum};
                    acc_d    = 48'd0;
                    cnt_d    = 5'd0;
                    busy_d   = 1'b1;
                    state_d  = ST_CALC;
                end
            end

            ST_CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                // Bit 23 is consumed on this edge, so acc_sum is the full
                // product; publish it directly rather than waiting a cycle.
                if (cnt_q == LAST_CNT) begin
                    result_d = acc_rounded[47:16];
                    stop_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            mplier_q     <= 24'd0;
            mcand_q      <= 48'd0;
            acc_q        <= 48'd0;
            cnt_q        <= 5'd0;
            result_q     <= 32'd0;
            busy_q       <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            mplier_q     <= mplier_d;
            mcand_q      <= mcand_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            busy_q       <= busy_d;
            stop_q       <= stop_d;
        end
    end

    assign Result    = result_q;
    assign Busy      = busy_q;
    assign Stop      = stop_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_square_q8_16.sv
// -----------------------------------------------------------------------------
// tb_square_q8_16
//
// Directed bench for square_q8_16. A table of {operand, expected square}
// records is applied in a loop. Hand-written sequences then cover the
// multi-cycle cases: held Start, Start re-pulsed during CALC, Start held
// across completion, reset mid-operation, and Start high at reset release.
// -----------------------------------------------------------------------------
module tb_square_q8_16;

    logic        clk;
    logic        Rst_n;
    logic        Start;
    logic [23:0] InpNum;
    logic [31:0] Result;
    logic        Busy;
    logic        Stop;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_exp;

    typedef struct {
        logic [23:0] x;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    square_q8_16 dut (
        .clk       (clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .InpNum    (InpNum),
        .Result    (Result),
        .Busy      (Busy),
        .Stop      (Stop),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Runs one operation. At the k-th falling edge after the accepting edge,
    // outputs reflect rising edge E(k-1), so Stop first seen at k=25 means
    // latency 24.
    //   hold      : cycles Start stays high (counting E0)
    //   disturb   : change InpNum and re-pulse Start mid-CALC
    //   via_reset : pulse reset with Start already high, so the first edge
    //               after release is the accepting edge
    task automatic do_square(input logic [23:0] x, input logic [31:0] exp,
                             input int hold, input bit disturb, input bit via_reset);
        int k;
        bit seen;
        @(negedge clk);
        InpNum = x;
        Start  = 1'b1;
        if (via_reset) begin
            Rst_n = 1'b0;
            #1;
            Rst_n = 1'b1;
            last_exp = 32'd0;
        end
        @(posedge clk);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) chk("busy_after_accept", {31'd0, Busy}, 32'd1);
            if (k == 12) chk("result_held_in_calc", Result, last_exp);
            if (disturb && k == 5) begin
                InpNum = x ^ 24'h5A5A5A;
                Start  = 1'b1;
            end else if (k >= hold) begin
                Start = 1'b0;
            end
            if (Stop) seen = 1'b1;
        end
        chk("stop_seen", {31'd0, seen}, 32'd1);
        chk("latency", k - 1, 32'd24);
        chk("result", Result, exp);
        @(negedge clk);
        chk("stop_one_cycle", {31'd0, Stop}, 32'd0);
        chk("busy_clear", {31'd0, Busy}, 32'd0);
        chk("state_idle", {30'd0, dbg_state}, 32'd0);
        chk("result_kept", Result, exp);
        last_exp = exp;
    endtask

    // Watches for n cycles and expects no Stop pulse.
    task automatic quiet(input int n);
        int stops;
        stops = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (Stop) stops++;
        end
        chk("no_extra_stop", stops, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vecs[0]  = '{24'h020000, 32'h0004_0000};  // 2.0  -> 4.0
        vecs[1]  = '{24'h018000, 32'h0002_4000};  // 1.5  -> 2.25
        vecs[2]  = '{24'hFFFFFF, 32'hFFFF_FE00};  // max, no wrap
        vecs[3]  = '{24'h0000B5, 32'h0000_0000};  // 32761  < 2^15
        vecs[4]  = '{24'h0000B6, 32'h0000_0001};  // 33124 >= 2^15
        vecs[5]  = '{24'h000100, 32'h0000_0001};  // exactly 2^16
        vecs[6]  = '{24'h000000, 32'h0000_0000};  // zero
        vecs[7]  = '{24'h030000, 32'h0009_0000};  // 3.0 -> 9.0
        vecs[8]  = '{24'h010000, 32'h0001_0000};  // 1.0 -> 1.0
        vecs[9]  = '{24'h000080, 32'h0000_0000};  // 16384 rounds down
        vecs[10] = '{24'h0000C0, 32'h0000_0001};  // 36864 rounds up
        vecs[11] = '{24'h0A0000, 32'h0064_0000};  // 10.0 -> 100.0

        Rst_n  = 1'b0;
        Start  = 1'b0;
        InpNum = 24'd0;
        #1;
        chk("reset_result", Result, 32'd0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_stop", {31'd0, Stop}, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, 32'd0);
        repeat (3) @(negedge clk);
        Rst_n = 1'b1;
        last_exp = 32'd0;

        for (int i = 0; i < 12; i++) begin
            do_square(vecs[i].x, vecs[i].exp, 1, 1'b0, 1'b0);
        end

        // Start held two cycles: exactly one Stop.
        do_square(24'h0A0000, 32'h0064_0000, 2, 1'b0, 1'b0);
        quiet(40);

        // InpNum change and Start re-pulse during CALC are ignored.
        do_square(24'h020000, 32'h0004_0000, 1, 1'b1, 1'b0);
        quiet(40);

        // Start held across completion does not retrigger.
        do_square(24'h018000, 32'h0002_4000, 100, 1'b0, 1'b0);
        quiet(30);
        Start = 1'b0;

        // Reset at cycle 10 of CALC: immediate abort, no Stop, Result cleared.
        @(negedge clk);
        InpNum = 24'h050000;
        Start  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            Start = 1'b0;
            if (k == 10) chk("busy_before_abort", {31'd0, Busy}, 32'd1);
        end
        Rst_n = 1'b0;
        #1;
        chk("abort_result", Result, 32'd0);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_stop", {31'd0, Stop}, 32'd0);
        chk("abort_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        Rst_n = 1'b1;
        quiet(40);
        last_exp = 32'd0;
        do_square(24'h030000, 32'h0009_0000, 1, 1'b0, 1'b0);

        // Start already high when reset is released counts as a rising edge.
        do_square(24'h0000B6, 32'h0000_0001, 1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
